// File: rtl/sha_2_round_ctrl.sv
// SHA-256 block sequencer and round engine: one compression round per clock, 16-word rolling schedule.
// Optional macro SHA2_ABORT_EN adds an abort input that discards the message in flight.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_IDLE   | waiting for a block; data_in_ready high once out of reset
// ST_ROUND  | rounds t = 0..63, one per clock
// ST_UPDATE | fold working regs into H0..H7
// ST_DIGEST | digest presented, waiting for data_out_ready
module sha_2_round_ctrl #(
  parameter int data_width = 32,
  parameter int num_rounds = 64
) (
  input  logic         clk,
  input  logic         sync_rst,
`ifdef SHA2_ABORT_EN
  input  logic         abort,
`endif
  input  logic [511:0] data_in_block,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [255:0] data_out,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic         busy
);

  localparam int CNT_W = $clog2(num_rounds);

  typedef logic [data_width-1:0] word_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_UPDATE, ST_DIGEST} state_t;

  localparam word_t H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t ror(input word_t x, input int n);
    return (x >> n) | (x << (data_width - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] round_cnt;
  word_t            w    [16];
  word_t            wk   [8];
  word_t            hreg [8];
  logic             last_q;
  logic             first_blk;
  logic             ready_q;
  logic             out_valid_q;
  logic [255:0]     out_q;
  logic             abort_i;

  word_t            t1;
  word_t            t2;
  word_t            w_new;
  word_t            h_sum [8];
  logic [255:0]     digest_next;
  logic             accept;

`ifdef SHA2_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // abort masks ready combinationally so a coincident handshake never lands
  assign data_in_ready  = ready_q & ~abort_i;
  assign data_out_valid = out_valid_q;
  assign data_out       = out_q;
  assign busy           = (state != ST_IDLE);
  assign accept         = (state == ST_IDLE) && data_in_valid && data_in_ready;

  always_comb begin
    t1    = wk[7] + bsig1(wk[4]) + ch(wk[4], wk[5], wk[6]) + K_TABLE[round_cnt] + w[0];
    t2    = bsig0(wk[0]) + maj(wk[0], wk[1], wk[2]);
    w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    digest_next = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = hreg[i] + wk[i];
      digest_next[255-32*i -: 32] = h_sum[i];
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state       <= ST_IDLE;
      round_cnt   <= '0;
      w           <= '{default: '0};
      wk          <= '{default: '0};
      hreg        <= H_INIT;
      last_q      <= 1'b0;
      first_blk   <= 1'b1;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (abort_i && (state != ST_IDLE)) begin
      state       <= ST_IDLE;
      round_cnt   <= '0;
      hreg        <= H_INIT;
      first_blk   <= 1'b1;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
              w[i] <= data_in_block[511-32*i -: 32];
            end
            last_q    <= data_in_last;
            ready_q   <= 1'b0;
            round_cnt <= '0;
            state     <= ST_ROUND;
            if (first_blk) begin
              wk   <= H_INIT;
              hreg <= H_INIT;
            end else begin
              wk <= hreg;
            end
          end
        end
        ST_ROUND: begin
          wk[0] <= t1 + t2;
          wk[1] <= wk[0];
          wk[2] <= wk[1];
          wk[3] <= wk[2];
          wk[4] <= wk[3] + t1;
          wk[5] <= wk[4];
          wk[6] <= wk[5];
          wk[7] <= wk[6];
          for (int i = 0; i < 15; i++) begin
            w[i] <= w[i+1];
          end
          w[15]     <= w_new;
          round_cnt <= round_cnt + 1'b1;
          if (round_cnt == CNT_W'(num_rounds - 1)) begin
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          hreg <= h_sum;
          if (last_q) begin
            first_blk   <= 1'b1;
            out_q       <= digest_next;
            out_valid_q <= 1'b1;
            state       <= ST_DIGEST;
          end else begin
            first_blk <= 1'b0;
            ready_q   <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_DIGEST: begin
          if (data_out_ready) begin
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_2_round_ctrl.sv
// Bench for sha_2_round_ctrl: known SHA-256 vectors plus random multi-block messages
// checked against a straight-from-the-algorithm SHA-256 compression model.
module tb_sha_2_round_ctrl;

  localparam logic [255:0] H_INIT_TB =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO_A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO_B = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         sync_rst;
  logic [511:0] data_in_block;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [255:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready;
  logic         busy;
`ifdef SHA2_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_rises = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_out_valid === 1'b1 && prev_valid !== 1'b1) valid_rises = valid_rises + 1;
    prev_valid = data_out_valid;
  end

  sha_2_round_ctrl dut (
    .clk            (clk),
    .sync_rst       (sync_rst),
`ifdef SHA2_ABORT_EN
    .abort          (abort),
`endif
    .data_in_block  (data_in_block),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .busy           (busy)
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Textbook SHA-256 compression with the full 64-entry schedule array
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] ws [64];
    logic [31:0] v [8];
    logic [31:0] hh [8];
    logic [31:0] s0, s1, tt1, tt2;
    logic [255:0] hout;
    for (int i = 0; i < 16; i++) ws[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(ws[i-15], 7) ^ rotr(ws[i-15], 18) ^ (ws[i-15] >> 3);
      s1 = rotr(ws[i-2], 17) ^ rotr(ws[i-2], 19) ^ (ws[i-2] >> 10);
      ws[i] = s1 + ws[i-7] + s0 + ws[i-16];
    end
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255-32*i -: 32];
      v[i]  = hh[i];
    end
    for (int t = 0; t < 64; t++) begin
      tt1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[t] + ws[t];
      tt2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + tt1;
      v[0] = tt1 + tt2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hh[i] + v[i];
    return hout;
  endfunction

  task automatic send_block(input logic [511:0] blk, input logic last, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    data_in_block = blk;
    data_in_last  = last;
    data_in_valid = 1'b1;
    while (data_in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (data_in_ready !== 1'b1) check_val("accept_timeout", 256'(data_in_ready), 256'(1));
    acc_cyc = cyc;
    @(negedge clk);
    data_in_valid = 1'b0;
    data_in_last  = ~last;
    for (int i = 0; i < 16; i++) data_in_block[32*i +: 32] = $urandom();
  endtask

  task automatic get_digest(input string tag, input logic [255:0] exp, input int stall,
                            input logic early_rdy, input int acc_cyc);
    int n;
    logic [255:0] held;
    n = 0;
    data_out_ready = early_rdy;
    while (data_out_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (data_out_valid !== 1'b1) begin
      check_val({tag, "_timeout"}, 256'(data_out_valid), 256'(1));
      data_out_ready = 1'b0;
      return;
    end
    check_val({tag, "_latency"}, 256'(cyc - acc_cyc), 256'(66));
    check_val({tag, "_digest"}, data_out, exp);
    if (!early_rdy) begin
      held = data_out;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check_val({tag, "_hold_data"}, data_out, held);
        check_val({tag, "_hold_inrdy"}, 256'(data_in_ready), 256'(0));
      end
      data_out_ready = 1'b1;
    end
    @(negedge clk);
    data_out_ready = 1'b0;
    check_val({tag, "_valid_drop"}, 256'(data_out_valid), 256'(0));
    check_val({tag, "_inrdy_back"}, 256'(data_in_ready), 256'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, r0, nb, stall;
    logic early;
    logic [255:0] h;
    logic [511:0] blk;

    sync_rst       = 1'b1;
    data_in_block  = '0;
    data_in_last   = 1'b0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
`ifdef SHA2_ABORT_EN
    abort          = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_val("rst_inrdy", 256'(data_in_ready), 256'(0));
    check_val("rst_outvalid", 256'(data_out_valid), 256'(0));
    check_val("rst_dout", data_out, 256'(0));
    check_val("rst_busy", 256'(busy), 256'(0));
    sync_rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_inrdy", 256'(data_in_ready), 256'(1));

    send_block(BLK_ABC, 1'b1, a1);
    check_val("abc_busy", 256'(busy), 256'(1));
    check_val("abc_inrdy_low", 256'(data_in_ready), 256'(0));
    get_digest("abc", DIG_ABC, 0, 1'b0, a1);

    send_block(BLK_EMPTY, 1'b1, a1);
    get_digest("empty", DIG_EMPTY, 0, 1'b1, a1);

    r0 = valid_rises;
    send_block(BLK_TWO_A, 1'b0, a1);
    send_block(BLK_TWO_B, 1'b1, a2);
    check_val("two_throughput", 256'(a2 - a1), 256'(66));
    check_val("two_no_early_digest", 256'(valid_rises - r0), 256'(0));
    get_digest("two", DIG_TWO, 0, 1'b0, a2);

    send_block(BLK_ABC, 1'b1, a1);
    get_digest("bp_abc", DIG_ABC, 20, 1'b0, a1);
    send_block(BLK_ABC, 1'b1, a1);
    get_digest("bp_abc_again", DIG_ABC, 0, 1'b0, a1);

    r0 = valid_rises;
    send_block(BLK_ABC, 1'b1, a1);
    repeat (30) @(negedge clk);
    sync_rst = 1'b1;
    @(negedge clk);
    sync_rst = 1'b0;
    repeat (80) @(negedge clk);
    check_val("rst_mid_no_digest", 256'(valid_rises - r0), 256'(0));
    check_val("rst_mid_busy", 256'(busy), 256'(0));
    send_block(BLK_EMPTY, 1'b1, a1);
    get_digest("rst_mid_empty", DIG_EMPTY, 0, 1'b0, a1);

`ifdef SHA2_ABORT_EN
    r0 = valid_rises;
    send_block(BLK_TWO_A, 1'b0, a1);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_to_idle", 256'(busy), 256'(0));
    data_in_valid = 1'b1;
    abort = 1'b1;
    check_val("abort_blocks_ready", 256'(data_in_ready), 256'(0));
    @(negedge clk);
    abort = 1'b0;
    data_in_valid = 1'b0;
    check_val("abort_idle_no_accept", 256'(busy), 256'(0));
    send_block(BLK_TWO_A, 1'b0, a1);
    send_block(BLK_TWO_B, 1'b1, a2);
    get_digest("abort_two", DIG_TWO, 0, 1'b0, a2);
    check_val("abort_one_digest", 256'(valid_rises - r0), 256'(1));
`endif

    for (int m = 0; m < 8; m++) begin
      nb = $urandom_range(1, 3);
      h  = H_INIT_TB;
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_block(blk, (b == nb - 1), a1);
        h = compress(h, blk);
      end
      stall = $urandom_range(0, 5);
      early = 1'($urandom_range(0, 1));
      get_digest($sformatf("rand%0d", m), h, stall, early, a1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
